// File: rtl/otf_conv_ctrl.sv
// Radix-2 on-the-fly conversion sequencer: folds signed digits (MSB first) into Q/Qm.
// Optional OTF_ERRCHK_EN flags the illegal digit code 2'b10 and ends the conversion early.
module otf_conv_ctrl #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             dig_valid,
    input  logic [1:0]       dig,
    output logic             dig_ready,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [WIDTH-1:0] res,
    output logic             busy,
    output logic             err
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state_reg, state_next;
    logic [WIDTH-1:0] q_reg, q_next;
    logic [WIDTH-1:0] qm_reg, qm_next;
    logic [CW-1:0]    cnt_reg, cnt_next;
    logic             accept;
    logic             dig_pos, dig_neg;

    assign dig_ready = (state_reg == RUN);
    assign busy      = (state_reg == RUN);
    assign res_valid = (state_reg == DONE);
    assign res       = q_reg;
    assign accept    = dig_valid && dig_ready;
    // Any code other than +1/-1 (including 2'b10) acts as digit 0 on the datapath.
    assign dig_pos   = (dig == 2'b01);
    assign dig_neg   = (dig == 2'b11);

`ifdef OTF_ERRCHK_EN
    logic err_reg, err_next;
    assign err = err_reg;
`else
    assign err = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            q_reg     <= '0;
            qm_reg    <= '1;
            cnt_reg   <= '0;
`ifdef OTF_ERRCHK_EN
            err_reg   <= 1'b0;
`endif
        end else begin
            state_reg <= state_next;
            q_reg     <= q_next;
            qm_reg    <= qm_next;
            cnt_reg   <= cnt_next;
`ifdef OTF_ERRCHK_EN
            err_reg   <= err_next;
`endif
        end
    end

    always_comb begin
        state_next = state_reg;
        q_next     = q_reg;
        qm_next    = qm_reg;
        cnt_next   = cnt_reg;
`ifdef OTF_ERRCHK_EN
        err_next   = err_reg;
`endif
        case (state_reg)
            IDLE, DONE: begin
                // start outranks res_ready in DONE: the pending result is dropped.
                if (start) begin
                    state_next = RUN;
                    q_next     = '0;
                    qm_next    = '1;
                    cnt_next   = '0;
`ifdef OTF_ERRCHK_EN
                    err_next   = 1'b0;
`endif
                end else if (state_reg == DONE && res_ready) begin
                    state_next = IDLE;
                end
            end
            RUN: begin
                if (accept) begin
`ifdef OTF_ERRCHK_EN
                    if (dig == 2'b10) begin
                        err_next   = 1'b1;
                        state_next = DONE;
                    end else
`endif
                    begin
                        if (dig_pos) begin
                            q_next  = {q_reg[WIDTH-2:0], 1'b1};
                            qm_next = {q_reg[WIDTH-2:0], 1'b0};
                        end else if (dig_neg) begin
                            q_next  = {qm_reg[WIDTH-2:0], 1'b1};
                            qm_next = {qm_reg[WIDTH-2:0], 1'b0};
                        end else begin
                            q_next  = {q_reg[WIDTH-2:0], 1'b0};
                            qm_next = {qm_reg[WIDTH-2:0], 1'b1};
                        end
                        cnt_next = cnt_reg + 1'b1;
                        if (cnt_reg == CW'(WIDTH - 1))
                            state_next = DONE;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end
endmodule

// File: tb/tb_otf_conv_ctrl.sv
// Directed bench for otf_conv_ctrl: a WIDTH=4 and a WIDTH=16 instance on one clock.
// Build with OTF_ERRCHK_EN defined to exercise the illegal-digit path.
module tb_otf_conv_ctrl;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0, dv = 1'b0, rr = 1'b0;
    logic [1:0]  dig = 2'b00;
    logic        dr, rv, busy, err;
    logic [15:0] res;
    logic        s4 = 1'b0, dv4 = 1'b0, rr4 = 1'b0;
    logic [1:0]  d4 = 2'b00;
    logic        dr4, rv4, busy4, err4;
    logic [3:0]  res4;

    int checks = 0;
    int errors = 0;
    logic [1:0]  dig_tab [16];
    logic [15:0] held;

    always #5 clk = ~clk;

    otf_conv_ctrl #(.WIDTH(16)) dut16 (
        .clk(clk), .rst_n(rst_n), .start(start), .dig_valid(dv), .dig(dig),
        .dig_ready(dr), .res_valid(rv), .res_ready(rr), .res(res), .busy(busy), .err(err)
    );
    otf_conv_ctrl #(.WIDTH(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .start(s4), .dig_valid(dv4), .dig(d4),
        .dig_ready(dr4), .res_valid(rv4), .res_ready(rr4), .res(res4), .busy(busy4), .err(err4)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end else begin
            $display("ok   %s: %0h", tag, obs);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_start;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic fill(input logic [1:0] d);
        for (int i = 0; i < 16; i++) dig_tab[i] = d;
    endtask

    // Feeds dig_tab[0..n-1]; optional random dig_valid gaps; bounded cycle budget.
    task automatic feed(input int n, input bit gaps);
        int acc = 0;
        int cyc = 0;
        bit a;
        while (acc < n && cyc < 400) begin
            dv  = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
            dig = dig_tab[acc];
            a   = dv && dr;
            tick();
            cyc++;
            if (a) acc++;
        end
        dv = 1'b0;
        if (acc != n) chk("feed_timeout", acc, n);
    endtask

    task automatic consume(input string tag);
        rr = 1'b1;
        tick();
        rr = 1'b0;
        chk(tag, {31'd0, rv}, 32'd0);
    endtask

    initial begin
        // Reset values
        tick();
        chk("rst_dig_ready", dr, 0);
        chk("rst_res_valid", rv, 0);
        chk("rst_busy", busy, 0);
        chk("rst_err", err, 0);
        chk("rst_res", res, 0);
        chk("rst_qm", dut16.qm_reg, 16'hFFFF);
        rst_n = 1'b1;
        tick();

        // WIDTH=4: +1,0,-1,+1 back-to-back -> 0111
        s4 = 1'b1; tick(); s4 = 1'b0;
        chk("w4_ready_after_start", dr4, 1);
        dv4 = 1'b1;
        d4 = 2'b01; tick();
        d4 = 2'b00; tick();
        d4 = 2'b11; tick();
        chk("w4_q_after3", dut4.q_reg, 4'b0011);
        chk("w4_qm_after3", dut4.qm_reg, 4'b0010);
        chk("w4_valid_early", rv4, 0);
        d4 = 2'b01; tick();
        dv4 = 1'b0;
        chk("w4_valid", rv4, 1);
        chk("w4_res", res4, 4'h7);
        rr4 = 1'b1; tick(); rr4 = 1'b0;
        chk("w4_consumed", rv4, 0);

        // WIDTH=16 uniform digit streams
        fill(2'b01); do_start(); feed(16, 0);
        chk("all_p1_valid", rv, 1);
        chk("all_p1_res", res, 16'hFFFF);
        consume("all_p1_consumed");
        fill(2'b11); do_start(); feed(16, 0);
        chk("all_m1_res", res, 16'h0001);
        consume("all_m1_consumed");
        fill(2'b00); do_start(); feed(16, 0);
        chk("all_0_res", res, 16'h0000);
        consume("all_0_consumed");

        // Mixed digits with gaps, result held 5 cycles with res_ready low: 7 << 12
        fill(2'b00);
        dig_tab[0] = 2'b01; dig_tab[2] = 2'b11; dig_tab[3] = 2'b01;
        do_start(); feed(16, 1);
        chk("gap_valid", rv, 1);
        chk("gap_res", res, 16'h7000);
        held = res;
        dv = 1'b1; dig = 2'b01;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("gap_hold_res", res, held);
            chk("gap_hold_ready", dr, 0);
        end
        dv = 1'b0;
        consume("gap_consumed");

        // Reset mid-RUN after 7 digits
        fill(2'b01); do_start(); feed(7, 0);
        rst_n = 1'b0; #1;
        chk("midrst_busy", busy, 0);
        chk("midrst_ready", dr, 0);
        chk("midrst_res", res, 0);
        chk("midrst_cnt", dut16.cnt_reg, 0);
        tick(); rst_n = 1'b1; tick();
        do_start(); feed(15, 0);
        chk("midrst_no_early_done", rv, 0);
        feed(1, 0);
        chk("midrst_valid", rv, 1);
        chk("midrst_res_after", res, 16'hFFFF);

        // start in DONE with res_ready same cycle: restart wins
        start = 1'b1; rr = 1'b1; tick(); start = 1'b0; rr = 1'b0;
        chk("restart_busy", busy, 1);
        chk("restart_valid", rv, 0);
        chk("restart_q", dut16.q_reg, 0);
        chk("restart_qm", dut16.qm_reg, 16'hFFFF);

        // start during RUN is ignored: exactly 16 accepts still complete it
        feed(5, 0);
        start = 1'b1; tick(); start = 1'b0;
        feed(10, 0);
        chk("run_start_not_done", rv, 0);
        feed(1, 0);
        chk("run_start_valid", rv, 1);
        chk("run_start_res", res, 16'hFFFF);
        consume("run_start_consumed");

`ifdef OTF_ERRCHK_EN
        dig_tab[0] = 2'b01; dig_tab[1] = 2'b01; dig_tab[2] = 2'b10;
        do_start(); feed(3, 0);
        chk("illegal_err", err, 1);
        chk("illegal_valid", rv, 1);
        chk("illegal_res", res, 16'h0003);
        do_start();
        chk("illegal_err_cleared", err, 0);
        fill(2'b01); feed(16, 0);
        consume("illegal_after_consumed");
`else
        fill(2'b10); do_start(); feed(16, 0);
        chk("illegal_as_zero_res", res, 16'h0000);
        chk("illegal_err_tied", err, 0);
        consume("illegal_consumed");
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/otf_conv_ctrl.md
# otf_conv_ctrl

Sequencer and register owner for the radix-2 on-the-fly converter datapath. It accepts a stream of signed-digit quotient digits (-1/0/+1), MSB first, one per handshake. It maintains the Q / Qm register pair through the 2-bit digit select, counts WIDTH digits, and presents the final conventional two's-complement result on a valid/ready output port. It sits between the digit-recurrence divider/sqrt iteration unit (digit producer) and the result consumer.

## Interface
- WIDTH, 16, number of digits per conversion = width of Q/Qm/result
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset
- start  in  1  one-cycle pulse; begins a conversion when in IDLE or DONE
- dig_valid  in  1  digit available
- dig  in  2  digit: 00=0, 01=+1, 11=-1, 10=illegal
- dig_ready  out  1  block accepts digit this cycle
- res_valid  out  1  result held stable
- res_ready  in  1  consumer takes result
- res  out  WIDTH  final Q
- busy  out  1  high in RUN
- err  out  1  sticky illegal-digit flag (only with OTF_ERRCHK_EN, else tied 0)

## Operation
- FSM states IDLE, RUN, DONE; reset enters IDLE.
- IDLE: dig_ready=0, res_valid=0. On start: Q<=0, Qm<=all-ones (-1), cnt<=0, err<=0, go RUN.
- RUN: dig_ready=1. A digit is accepted when dig_valid && dig_ready. Updates (shift left by one, keep WIDTH LSBs):
  - +1: Q<={Q,1}, Qm<={Q,0}
  - 0: Q<={Q,0}, Qm<={Qm,1}
  - -1: Q<={Qm,1}, Qm<={Qm,0}
- Invariant after every accept: Qm == Q-1 mod 2^WIDTH.
- cnt increments per accepted digit. On the accept with cnt==WIDTH-1, go DONE. dig_valid low stalls with no state change.
- DONE: res_valid=1, res=Q, dig_ready=0. On res_valid && res_ready, go IDLE. start in DONE restarts directly: the result is discarded, Q/Qm/cnt are re-initialised, and the FSM goes RUN.
- start while in RUN is ignored.
- Illegal digit 10 without OTF_ERRCHK_EN is treated as 0.

## Timing
- Reset values: dig_ready=0, res_valid=0, busy=0, err=0, res=0, Q=0, Qm=all-ones, cnt=0. Reset asserted mid-RUN or mid-DONE aborts immediately to these values.
- start -> RUN on the next edge; dig_ready is high the cycle after start.
- Throughput is one digit per cycle. With back-to-back digits, res_valid rises on the cycle after the WIDTH-th accept: latency from the first accept is WIDTH cycles.
- res is registered and stable while res_valid=1 and res_ready=0.
- Same-cycle res_ready and start in DONE: start wins, and the result is consumed and dropped.
- Back-to-back conversions: the earliest next start is the cycle res_valid&&res_ready occurs, or any later cycle.

## Configuration
- OTF_ERRCHK_EN defined: accepting dig=10 sets err=1 (sticky until the next start), the digit is not applied, and the FSM goes DONE immediately with res_valid=1 and res = current Q.
- OTF_ERRCHK_EN undefined: no checking logic, err tied 0, and 10 is treated as digit 0.

## Test plan
- WIDTH=4, start, digits +1,0,-1,+1 back-to-back -> res=4'b0111 (7), res_valid on the 4th cycle after the first accept; intermediate Q/Qm after the 3rd digit = 0011/0010.
- WIDTH=16, 16x +1 -> res=16'hFFFF; 16x -1 -> res=16'h0001; 16x 0 -> res=16'h0000.
- Random dig_valid gaps and res_ready held low 5 cycles -> same res as the gapless run, res stable throughout, no extra digit accepted (dig_ready=0 in DONE).
- Reset pulled low after 7 of 16 digits, then start -> all outputs at reset values; the next conversion of 16x +1 gives 16'hFFFF, with no carry-over of cnt.
- start asserted in RUN (ignored) and in DONE with res_ready=1 same cycle -> conversion restarts, Q=0, Qm=16'hFFFF, busy=1 next cycle.
- OTF_ERRCHK_EN: digits +1,+1,10 -> err=1, res_valid next cycle, res=16'h0003; the next start clears err.
